// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared opcode, ALU-op, state and strobe types for the CPU control path.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int PC_W_DEFAULT = 8;
    localparam int DATA_W       = 8;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_MOV = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_CMP = 4'h8,
        OP_JMP = 4'h9,
        OP_JZ  = 4'hA,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_PASS_B = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_RD_A   = 3'd3,
        S_RD_B   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef struct packed {
        logic    imem_req;
        logic    c_a;
        logic    c_b;
        logic    c_imm;
        logic    gpr_oe;
        logic    gpr_we;
        logic    alu_opa_ld;
        alu_op_e alu_op;
        logic    alu_oe;
        logic    flags_we;
        logic    pc_ld;
        logic    illegal;
        logic    halted;
    } strobe_t;

    // CMP shares the subtractor; MOV routes operand B straight through.
    function automatic alu_op_e alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB, OP_CMP: return ALU_SUB;
            OP_AND:         return ALU_AND;
            OP_OR:          return ALU_OR;
            OP_XOR:         return ALU_XOR;
            OP_MOV:         return ALU_PASS_B;
            default:        return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_if
// Purpose  : Fetch handshake, decode inputs and datapath strobes of the sequencer.
// Revision : 1.0
// ============================================================================
interface cpu_ctrl_if #(
    parameter int PC_W = cpu_pkg::PC_W_DEFAULT
);
    logic                       run;
    logic [PC_W-1:0]            imem_addr;
    logic                       imem_req;
    logic                       imem_ack;
    logic                       ir_load;
    logic [3:0]                 c_opcode;
    logic                       zero;
    logic [cpu_pkg::DATA_W-1:0] bus;
    logic                       c_a;
    logic                       c_b;
    logic                       c_imm;
    logic                       gpr_oe;
    logic                       gpr_we;
    logic                       alu_opa_ld;
    logic [2:0]                 alu_op;
    logic                       alu_oe;
    logic                       flags_we;
    logic [PC_W-1:0]            pc;
    logic                       halted;
    logic                       illegal;

    modport master (
        input  run, imem_ack, c_opcode, zero, bus,
        output imem_addr, imem_req, ir_load, c_a, c_b, c_imm, gpr_oe, gpr_we,
               alu_opa_ld, alu_op, alu_oe, flags_we, pc, halted, illegal
    );

    modport slave (
        output run, imem_ack, c_opcode, zero, bus,
        input  imem_addr, imem_req, ir_load, c_a, c_b, c_imm, gpr_oe, gpr_we,
               alu_opa_ld, alu_op, alu_oe, flags_we, pc, halted, illegal
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Pure table from (state, opcode, zero) to the datapath strobe vector.
// Revision : 1.0
// ============================================================================
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] opcode_i,
    input  logic       zero_i,
    output strobe_t    strobe_o
);

    always_comb begin
        strobe_o = '0;
        unique case (state_i)
            S_FETCH:  strobe_o.imem_req = 1'b1;
            S_DECODE: strobe_o.illegal  = is_illegal(opcode_i);
            S_RD_A: begin
                strobe_o.c_a        = 1'b1;
                strobe_o.gpr_oe     = 1'b1;
                strobe_o.alu_opa_ld = 1'b1;
            end
            S_RD_B: begin
                strobe_o.c_b    = 1'b1;
                strobe_o.gpr_oe = 1'b1;
                strobe_o.alu_op = alu_op_of(opcode_i);
            end
            S_WB: begin
                strobe_o.alu_op = alu_op_of(opcode_i);
                case (opcode_i)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        strobe_o.c_a      = 1'b1;
                        strobe_o.alu_oe   = 1'b1;
                        strobe_o.gpr_we   = 1'b1;
                        strobe_o.flags_we = 1'b1;
                    end
                    OP_CMP: begin
                        strobe_o.alu_oe   = 1'b1;
                        strobe_o.flags_we = 1'b1;
                    end
                    OP_MOV: begin
                        strobe_o.c_a    = 1'b1;
                        strobe_o.alu_oe = 1'b1;
                        strobe_o.gpr_we = 1'b1;
                    end
                    OP_LDI: begin
                        strobe_o.c_a    = 1'b1;
                        strobe_o.c_imm  = 1'b1;
                        strobe_o.gpr_we = 1'b1;
                    end
                    OP_JMP: begin
                        strobe_o.c_imm = 1'b1;
                        strobe_o.pc_ld = 1'b1;
                    end
                    OP_JZ: begin
                        strobe_o.c_imm = 1'b1;
                        strobe_o.pc_ld = zero_i;
                    end
                    default: ;
                endcase
            end
            S_HALT:   strobe_o.halted = 1'b1;
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl
// Purpose  : Multi-cycle fetch/decode/execute sequencer owning the program counter.
// Revision : 1.0
// ============================================================================
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
)(
    input  logic       clk,
    input  logic       reset_n,
    cpu_ctrl_if.master ctl
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    strobe_t         strobe;
    logic            fetch_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (ctl.run) state_d = S_FETCH;
            S_FETCH:  if (ctl.imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.c_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: state_d = S_RD_A;
                    OP_MOV:                                        state_d = S_RD_B;
                    OP_LDI, OP_JMP, OP_JZ:                         state_d = S_WB;
                    OP_HLT:                                        state_d = S_HALT;
                    default:                                       state_d = S_FETCH;
                endcase
            end
            S_RD_A:   state_d = S_RD_B;
            S_RD_B:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // A branch load in WB replaces the increment taken at the fetch edge.
    assign fetch_done = strobe.imem_req && ctl.imem_ack;

    always_comb begin
        pc_d = pc_q;
        if (fetch_done)
            pc_d = pc_q + PC_W'(1);
        else if (strobe.pc_ld)
            pc_d = PC_W'(ctl.bus);
    end

    ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (ctl.c_opcode),
        .zero_i   (ctl.zero),
        .strobe_o (strobe)
    );

    always_comb begin
        ctl.imem_addr  = pc_q;
        ctl.pc         = pc_q;
        ctl.imem_req   = strobe.imem_req;
        ctl.ir_load    = fetch_done;
        ctl.c_a        = strobe.c_a;
        ctl.c_b        = strobe.c_b;
        ctl.c_imm      = strobe.c_imm;
        ctl.gpr_oe     = strobe.gpr_oe;
        ctl.gpr_we     = strobe.gpr_we;
        ctl.alu_opa_ld = strobe.alu_opa_ld;
        ctl.alu_op     = strobe.alu_op;
        ctl.alu_oe     = strobe.alu_oe;
        ctl.flags_we   = strobe.flags_we;
        ctl.halted     = strobe.halted;
        ctl.illegal    = strobe.illegal;
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl
// Purpose  : Randomised scoreboard bench for cpu_ctrl against an opcode-table model.
// Revision : 1.0
// ============================================================================
module tb_cpu_ctrl;
    import cpu_pkg::*;

    localparam int PC_W = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cpu_ctrl_if #(.PC_W(PC_W)) ctl();

    cpu_ctrl #(.PC_W(PC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctl     (ctl)
    );

    int checks   = 0;
    int failures = 0;

    // Instruction register stand-in: opcode[15:12], fields[11:8], imm[7:0].
    logic [15:0] ir_in = '0;
    logic [15:0] ir_q  = '0;
    always @(posedge clk) if (ctl.ir_load) ir_q <= ir_in;
    assign ctl.c_opcode = ir_q[15:12];
    assign ctl.bus      = ctl.c_imm ? ir_q[7:0] : ~ir_q[7:0];

    // Scoreboard: per-cycle strobe steps, fetch addresses, fetch-to-fetch latencies.
    logic [11:0]     q_step[$];
    int              q_fetch[$];
    int              q_lat[$];
    logic [PC_W-1:0] model_pc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] vec(input logic ca, input logic cb, input logic ci,
                                        input logic goe, input logic gwe, input logic opa,
                                        input logic aoe, input logic fwe, input logic ill,
                                        input logic [2:0] op);
        return {ca, cb, ci, goe, gwe, opa, aoe, fwe, ill, op};
    endfunction

    function automatic logic [11:0] observed();
        return {ctl.c_a, ctl.c_b, ctl.c_imm, ctl.gpr_oe, ctl.gpr_we, ctl.alu_opa_ld,
                ctl.alu_oe, ctl.flags_we, ctl.illegal, ctl.alu_op};
    endfunction

    // Reference behaviour: what one fetched instruction must produce, cycle by cycle.
    task automatic model_issue(input logic [3:0] op, input logic [7:0] imm, input logic z);
        int         lat;
        logic [2:0] f;
        q_fetch.push_back(int'(model_pc));
        model_pc = model_pc + 1'b1;
        if (op >= 4'd3 && op <= 4'd7) begin
            f = 3'(op - 4'd3);
            q_step.push_back(vec(1,0,0,1,0,1,0,0,0,3'd0));
            q_step.push_back(vec(0,1,0,1,0,0,0,0,0,f));
            q_step.push_back(vec(1,0,0,0,1,0,1,1,0,f));
            lat = 5;
        end else begin
            case (op)
                4'h0: lat = 2;
                4'h1: begin
                    q_step.push_back(vec(1,0,1,0,1,0,0,0,0,3'd0));
                    lat = 3;
                end
                4'h2: begin
                    q_step.push_back(vec(0,1,0,1,0,0,0,0,0,3'd5));
                    q_step.push_back(vec(1,0,0,0,1,0,1,0,0,3'd5));
                    lat = 4;
                end
                4'h8: begin
                    q_step.push_back(vec(1,0,0,1,0,1,0,0,0,3'd0));
                    q_step.push_back(vec(0,1,0,1,0,0,0,0,0,3'd1));
                    q_step.push_back(vec(0,0,0,0,0,0,1,1,0,3'd1));
                    lat = 5;
                end
                4'h9: begin
                    q_step.push_back(vec(0,0,1,0,0,0,0,0,0,3'd0));
                    model_pc = imm;
                    lat = 3;
                end
                4'hA: begin
                    q_step.push_back(vec(0,0,1,0,0,0,0,0,0,3'd0));
                    if (z) model_pc = imm;
                    lat = 3;
                end
                4'hF: lat = -1;
                default: begin
                    q_step.push_back(vec(0,0,0,0,0,0,0,0,1,3'd0));
                    lat = 2;
                end
            endcase
        end
        q_lat.push_back(lat);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    initial begin : monitor
        int          cnt;
        int          cur_lat;
        bit          meas;
        logic [11:0] obs;
        meas = 0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            obs = observed();
            check("ab_exclusive", 32'(ctl.c_a & ctl.c_b), 32'd0);
            check("bus_single_driver",
                  32'((32'(ctl.gpr_oe) + 32'(ctl.alu_oe) + 32'(ctl.c_imm)) <= 32'd1), 32'd1);
            check("ir_load_gate", 32'(ctl.ir_load), 32'(ctl.imem_req & ctl.imem_ack));
            check("addr_is_pc", 32'(ctl.imem_addr), 32'(ctl.pc));
            if (meas) begin
                cnt++;
                if (ctl.imem_req) begin
                    check("fetch_to_fetch", 32'(cnt), 32'(cur_lat));
                    meas = 0;
                end
            end
            if (ctl.imem_req && ctl.imem_ack) begin
                if (q_fetch.size() == 0) check("unexpected_fetch", 32'd1, 32'd0);
                else check("fetch_addr", 32'(ctl.imem_addr), 32'(q_fetch.pop_front()));
                cur_lat = (q_lat.size() != 0) ? q_lat.pop_front() : -1;
                meas    = (cur_lat > 0);
                cnt     = 0;
            end
            if (|obs) begin
                if (q_step.size() == 0) check("unexpected_strobe", 32'(obs), 32'd0);
                else check("strobe_step", 32'(obs), 32'(q_step.pop_front()));
            end
            if (!reset_n) meas = 0;
        end
    end

    // Wait for the fetch request (ack noise meanwhile must be ignored), stall, then ack.
    task automatic serve(input logic [3:0] op, input logic [7:0] imm, input logic z, input int delay);
        int n;
        n = 0;
        while (!ctl.imem_req) begin
            ctl.imem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
            if (n > 20) begin
                ctl.imem_ack = 1'b0;
                check("fetch_timeout", 32'd0, 32'd1);
                return;
            end
        end
        ctl.imem_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            check("stall_req", 32'(ctl.imem_req), 32'd1);
            check("stall_pc", 32'(ctl.pc), 32'(model_pc));
            @(posedge clk); #1;
        end
        check("fetch_req", 32'(ctl.imem_req), 32'd1);
        ir_in        = {op, 4'($urandom_range(0, 15)), imm};
        ctl.zero     = z;
        ctl.imem_ack = 1'b1;
        model_issue(op, imm, z);
        @(posedge clk); #1;
        ctl.imem_ack = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset_n      = 1'b0;
        ctl.run      = 1'b0;
        ctl.imem_ack = 1'b0;
        ctl.zero     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", 32'(ctl.pc), 32'd0);
        check("reset_req", 32'(ctl.imem_req), 32'd0);
        check("reset_halted", 32'(ctl.halted), 32'd0);
        check("reset_strobes", 32'(observed()), 32'd0);
        reset_n  = 1'b1;
        model_pc = '0;
        ctl.run  = 1'b1;
        check("idle_pc", 32'(ctl.pc), 32'd0);
        check("idle_req", 32'(ctl.imem_req), 32'd0);
        @(posedge clk); #1;
        check("run_req", 32'(ctl.imem_req), 32'd1);

        serve(4'h1, 8'h5A, 1'b0, 0);
        check("pc_after_ack", 32'(ctl.pc), 32'd1);
        serve(4'h3, 8'h00, 1'b0, 0);
        serve(4'h0, 8'h00, 1'b0, 3);
        serve(4'hA, 8'h40, 1'b0, 0);
        serve(4'hA, 8'h40, 1'b1, 0);
        serve(4'hC, 8'h00, 1'b0, 0);
        serve(4'h8, 8'h00, 1'b1, 1);
        serve(4'h2, 8'h00, 1'b0, 0);

        for (int k = 0; k < 300; k++)
            serve(4'($urandom_range(0, 14)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

        serve(4'hF, 8'h00, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (ctl.imem_req || !ctl.halted) n++;
            @(posedge clk); #1;
        end
        check("halt_sticky_cycles_bad", 32'(n), 32'd0);
        check("halted_flag", 32'(ctl.halted), 32'd1);

        reset_n = 1'b0;
        ctl.run = 1'b0;
        @(posedge clk); #1;
        check("halt_cleared", 32'(ctl.halted), 32'd0);
        check("halt_reset_pc", 32'(ctl.pc), 32'd0);
        reset_n  = 1'b1;
        model_pc = '0;
        @(posedge clk); #1;
        check("idle_no_run_req", 32'(ctl.imem_req), 32'd0);

        ctl.run = 1'b1;
        serve(4'h3, 8'h00, 1'b0, 0);
        n = 0;
        while (!ctl.gpr_we && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("add_wb_seen", 32'(ctl.gpr_we), 32'd1);
        reset_n = 1'b0;
        ctl.run = 1'b0;
        @(posedge clk); #1;
        check("midwb_no_write", 32'(ctl.gpr_we), 32'd0);
        check("midwb_strobes", 32'(observed()), 32'd0);
        check("midwb_pc", 32'(ctl.pc), 32'd0);
        check("midwb_req", 32'(ctl.imem_req), 32'd0);
        reset_n  = 1'b1;
        model_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(observed()), 32'd0);

        check("steps_drained", 32'(q_step.size()), 32'd0);
        check("fetches_drained", 32'(q_fetch.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
